// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle of the register-file write arbiter: per-requester
// valid/address/value with a one-hot ready, plus the loader's lock handshake.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [3*NUM_REQ-1:0]  req_address;
  logic [16*NUM_REQ-1:0] req_value;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  lock_req;
  logic                  lock_ack;
  logic                  lock_timeout;

  modport master (
    output req_valid, req_address, req_value, lock_req,
    input  req_ready, lock_ack, lock_timeout
  );

  modport slave (
    input  req_valid, req_address, req_value, lock_req,
    output req_ready, lock_ack, lock_timeout
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single write port of the 8x16 register file
// between loader (0), ALU writeback (1) and memory-load writeback (2).
// The loader may take an exclusive lock, bounded by a watchdog timeout.
module regfile_write_arbiter #(
  parameter int NUM_REQ          = 3,
  parameter int LOCK_TIMEOUT     = 64,
  parameter int ZERO_REG_PROTECT = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  regfile_write_arbiter_if.slave  req,
  output logic                    rf_write,
  output logic [2:0]              rf_write_address,
  output logic [15:0]             rf_write_value,
  output logic [15:0]             write_count
);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  // Counter value seen in the last permitted LOCK cycle.
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t               state, state_next;
  logic [1:0]           ptr, ptr_next;
  logic [15:0]          lock_cnt, lock_cnt_next;
  logic                 relock_block, relock_block_next;
  logic                 lock_timeout_q;
  logic                 timeout_fire;

  logic                 exclusive;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [1:0]           grant_idx;
  logic [1:0]           cand;
  logic [2:0]           sel_address;
  logic [15:0]          sel_value;
  logic                 forward;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'(NUM_REQ - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // State register: FSM state, round-robin pointer, lock watchdog, sticky flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!RST_N) begin
      state          <= ARB;
      ptr            <= '0;
      lock_cnt       <= '0;
      relock_block   <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      lock_cnt     <= lock_cnt_next;
      relock_block <= relock_block_next;
      if (timeout_fire) lock_timeout_q <= 1'b1;
    end
  end

  // Next-state logic: lock entry/exit, watchdog and pointer advance.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a variable unassigned (no latches).
    state_next        = state;
    ptr_next          = ptr;
    lock_cnt_next     = lock_cnt;
    relock_block_next = relock_block;
    timeout_fire      = 1'b0;

    if (|grant) ptr_next = rr_next(grant_idx);

    unique case (state)
      ARB: begin
        // One low cycle of lock_req re-arms locking after a forced release.
        if (!req.lock_req) relock_block_next = 1'b0;
        if (req.lock_req && !relock_block) begin
          state_next    = LOCK;
          lock_cnt_next = '0;
        end
      end
      LOCK: begin
        if (lock_cnt == LOCK_LAST) begin
          // Watchdog wins even if lock_req drops in this same cycle.
          state_next        = ARB;
          ptr_next          = 2'd1;
          lock_cnt_next     = '0;
          relock_block_next = 1'b1;
          timeout_fire      = 1'b1;
        end else if (!req.lock_req) begin
          state_next    = ARB;
          ptr_next      = 2'd1;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + 16'd1;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Output logic: eligibility, rotating-priority grant and granted payload.
  always_comb begin
    exclusive = (state == LOCK) || (req.lock_req && !relock_block);
    eligible  = exclusive ? (req.req_valid & NUM_REQ'(1)) : req.req_valid;

    grant     = '0;
    grant_idx = '0;
    cand      = ptr;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant == '0 && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
      cand = rr_next(cand);
    end
    if (!RST_N) grant = '0;

    sel_address = '0;
    sel_value   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_address = req.req_address[3*i +: 3];
        sel_value   = req.req_value[16*i +: 16];
      end
    end

    // A protected write to r0 is still handshaken, just never forwarded.
    forward = (|grant) && !((ZERO_REG_PROTECT != 0) && (sel_address == 3'd0));
  end

  assign req.req_ready    = grant;
  assign req.lock_ack     = (state == LOCK);
  assign req.lock_timeout = lock_timeout_q;

  // Write path: register the accepted transfer one cycle after the handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rf_write         <= 1'b0;
      rf_write_address <= '0;
      rf_write_value   <= '0;
      write_count      <= '0;
    end else begin
      rf_write <= 1'b0;
      if (forward) begin
        rf_write         <= 1'b1;
        rf_write_address <= sel_address;
        rf_write_value   <= sel_value;
        if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: two arbiters (A: default timeout, no r0 protect;
// B: timeout 4, r0 protect) share one directed stimulus stream and are both
// compared every cycle against a behavioural model of the write-sharing rules.
module tb_regfile_write_arbiter;

  localparam int TO_A = 64;
  localparam int TO_B = 4;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic [2:0]  valid    = '0;
  logic [8:0]  addr     = '0;
  logic [47:0] value    = '0;
  logic        lock_req = 1'b0;

  always #5 CLK = ~CLK;

  regfile_write_arbiter_if if_a ();
  regfile_write_arbiter_if if_b ();

  assign if_a.req_valid   = valid;
  assign if_a.req_address = addr;
  assign if_a.req_value   = value;
  assign if_a.lock_req    = lock_req;
  assign if_b.req_valid   = valid;
  assign if_b.req_address = addr;
  assign if_b.req_value   = value;
  assign if_b.lock_req    = lock_req;

  logic [2:0]  ready_o   [2];
  logic        ack_o     [2];
  logic        tflag_o   [2];
  logic        rf_write_o[2];
  logic [2:0]  rf_addr_o [2];
  logic [15:0] rf_val_o  [2];
  logic [15:0] count_o   [2];

  assign ready_o[0] = if_a.req_ready;
  assign ack_o[0]   = if_a.lock_ack;
  assign tflag_o[0] = if_a.lock_timeout;
  assign ready_o[1] = if_b.req_ready;
  assign ack_o[1]   = if_b.lock_ack;
  assign tflag_o[1] = if_b.lock_timeout;

  regfile_write_arbiter #(.NUM_REQ(3), .LOCK_TIMEOUT(TO_A), .ZERO_REG_PROTECT(0)) u_a (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .req              (if_a.slave),
    .rf_write         (rf_write_o[0]),
    .rf_write_address (rf_addr_o[0]),
    .rf_write_value   (rf_val_o[0]),
    .write_count      (count_o[0])
  );

  regfile_write_arbiter #(.NUM_REQ(3), .LOCK_TIMEOUT(TO_B), .ZERO_REG_PROTECT(1)) u_b (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .req              (if_b.slave),
    .rf_write         (rf_write_o[1]),
    .rf_write_address (rf_addr_o[1]),
    .rf_write_value   (rf_val_o[1]),
    .write_count      (count_o[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ptr   [2];  // requester that gets first look next time
  bit m_lock  [2];  // loader holds the port exclusively
  int m_cnt   [2];  // cycles already spent locked
  bit m_block [2];  // forced release seen, waiting for lock_req low
  bit m_tflag [2];
  bit m_wr    [2];
  int m_addr  [2];
  int m_val   [2];
  int m_count [2];

  function automatic int p_to(input int k);
    return (k == 0) ? TO_A : TO_B;
  endfunction

  // Index of the requester granted this cycle, or -1.
  function automatic int model_grant(input int k);
    bit only_loader;
    int i;
    if (!RST_N) return -1;
    only_loader = m_lock[k] || (lock_req && !m_block[k]);
    for (int j = 0; j < 3; j++) begin
      i = (m_ptr[k] + j) % 3;
      if (valid[i] && (i == 0 || !only_loader)) return i;
    end
    return -1;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < 2; k++) begin
        m_ptr[k] <= 0; m_lock[k] <= 0; m_cnt[k] <= 0; m_block[k] <= 0;
        m_tflag[k] <= 0; m_wr[k] <= 0; m_addr[k] <= 0; m_val[k] <= 0; m_count[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int g;
        int a;
        g = model_grant(k);
        m_wr[k] <= 0;
        if (g >= 0) begin
          a = int'(addr[3*g +: 3]);
          m_ptr[k] <= (g + 1) % 3;
          if (!(k == 1 && a == 0)) begin
            m_wr[k]    <= 1;
            m_addr[k]  <= a;
            m_val[k]   <= int'(value[16*g +: 16]);
            m_count[k] <= (m_count[k] == 65535) ? 65535 : m_count[k] + 1;
          end
        end
        if (!m_lock[k]) begin
          if (!lock_req) m_block[k] <= 0;
          else if (!m_block[k]) begin
            m_lock[k] <= 1;
            m_cnt[k]  <= 0;
          end
        end else begin
          m_cnt[k] <= m_cnt[k] + 1;
          if (m_cnt[k] + 1 >= p_to(k)) begin
            m_lock[k] <= 0; m_tflag[k] <= 1; m_block[k] <= 1; m_ptr[k] <= 1;
          end else if (!lock_req) begin
            m_lock[k] <= 0; m_ptr[k] <= 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      int g;
      logic [2:0] exp_ready;
      string tg;
      tg = (k == 0) ? "a" : "b";
      g = model_grant(k);
      exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
      check({tg, ".req_ready"},    ready_o[k],    exp_ready);
      check({tg, ".lock_ack"},     ack_o[k],      m_lock[k]);
      check({tg, ".lock_timeout"}, tflag_o[k],    m_tflag[k]);
      check({tg, ".rf_write"},     rf_write_o[k], m_wr[k]);
      check({tg, ".rf_addr"},      rf_addr_o[k],  m_addr[k]);
      check({tg, ".rf_value"},     rf_val_o[k],   m_val[k]);
      check({tg, ".write_count"},  count_o[k],    m_count[k]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    mid();
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    logic [2:0] seq [4];
    int base;
    int n_ack;
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

    // Reset with everyone requesting: no grants while reset is held.
    valid = 3'b111;
    addr  = {3'd6, 3'd3, 3'd1};
    value = {16'h2222, 16'hBEEF, 16'h1111};
    mid();
    check("reset.ready_a", ready_o[0], 3'b000);
    check("reset.ready_b", ready_o[1], 3'b000);
    mid();
    check("reset.count_a", count_o[0], 16'h0000);
    step();
    RST_N = 1'b1;

    // Round-robin order 0,1,2,0 with data one cycle behind.
    for (int n = 0; n < 4; n++) begin
      mid();
      check("rr.grant", ready_o[0], seq[n]);
      if (n == 2) begin
        check("rr.rf_addr",  rf_addr_o[0], 3'd3);
        check("rr.rf_value", rf_val_o[0],  16'hBEEF);
      end
      step();
    end

    // Lock burst: loader writes r0..r7 while 1 and 2 wait.
    lock_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr[2:0]   = 3'(i);
      value[15:0] = 16'h1000 + 16'(i);
      mid();
      check("lock.grant", ready_o[0], 3'b001);
      if (i > 0) check("lock.ack", ack_o[0], 1'b1);
      step();
    end
    valid = 3'b110;
    lock_req = 1'b0;
    mid();
    check("lock.exit_ready", ready_o[0], 3'b000);
    check("lock.last_addr", rf_addr_o[0], 3'd7);
    check("lock.last_value", rf_val_o[0], 16'h1007);
    step();
    mid();
    check("lock.after", ready_o[0], 3'b010);
    check("lock.ack_low", ack_o[0], 1'b0);
    step();
    valid = 3'b000;
    step();

    // Watchdog on B (timeout 4) with lock_req held.
    do_reset();
    valid = 3'b001;
    addr  = {3'd6, 3'd3, 3'd2};
    lock_req = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      mid();
      if (ack_o[1]) n_ack++;
      step();
    end
    check("timeout.lock_cycles", n_ack, 4);
    check("timeout.flag", tflag_o[1], 1'b1);
    check("timeout.a_still_locked", ack_o[0], 1'b1);
    lock_req = 1'b0;
    step();
    lock_req = 1'b1;
    mid();
    check("timeout.not_yet", ack_o[1], 1'b0);
    step();
    mid();
    check("timeout.relock", ack_o[1], 1'b1);
    check("timeout.sticky", tflag_o[1], 1'b1);
    step();
    lock_req = 1'b0;
    valid = 3'b000;
    step();
    step();

    // r0 protection on B: handshake completes, nothing forwarded.
    valid = 3'b100;
    addr  = {3'd0, 3'd3, 3'd1};
    value = {16'hFFFF, 16'hBEEF, 16'h1111};
    mid();
    check("zrp.ready", ready_o[1], 3'b100);
    base = m_count[1];
    step();
    addr[8:6]    = 3'd5;
    value[47:32] = 16'h0055;
    mid();
    check("zrp.no_write", rf_write_o[1], 1'b0);
    check("zrp.count_hold", count_o[1], 16'(base));
    step();
    valid = 3'b000;
    mid();
    check("zrp.write5", rf_write_o[1], 1'b1);
    check("zrp.addr5", rf_addr_o[1], 3'd5);
    check("zrp.count_inc", count_o[1], 16'(base + 1));
    step();

    // Withdrawal: requester 1 drops valid before its turn.
    valid = 3'b011;
    mid();
    check("wd.first", ready_o[0], 3'b001);
    step();
    valid = 3'b000;
    mid();
    check("wd.ready", ready_o[0], 3'b000);
    step();
    valid = 3'b111;
    mid();
    check("wd.no_write", rf_write_o[0], 1'b0);
    check("wd.ptr_kept", ready_o[0], 3'b010);
    step();

    // Saturation of write_count.
    valid = 3'b010;
    repeat (65536) step();
    mid();
    check("sat.count_a", count_o[0], 16'hFFFF);
    check("sat.count_b", count_o[1], 16'hFFFF);
    step();
    mid();
    check("sat.hold", count_o[0], 16'hFFFF);
    check("sat.still_writing", rf_write_o[0], 1'b1);
    step();
    valid = 3'b000;
    step();

    // Asynchronous reset in the middle of a locked, granted cycle.
    valid = 3'b001;
    addr[2:0] = 3'd4;
    lock_req = 1'b1;
    step();
    step();
    mid();
    check("arst.locked", ack_o[0], 1'b1);
    check("arst.granting", ready_o[0], 3'b001);
    #2 RST_N = 1'b0;
    #1;
    check("arst.ready", ready_o[0], 3'b000);
    check("arst.ack", ack_o[0], 1'b0);
    check("arst.rf_write", rf_write_o[0], 1'b0);
    check("arst.count", count_o[0], 16'h0000);
    check("arst.addr", rf_addr_o[0], 3'd0);
    check("arst.flag_b", tflag_o[1], 1'b0);
    @(posedge CLK);
    #1;
    valid = 3'b000;
    lock_req = 1'b0;
    RST_N = 1'b1;
    mid();
    check("arst.no_pulse", rf_write_o[0], 1'b0);
    check("arst.ack_after", ack_o[0], 1'b0);
    step();
    valid = 3'b010;
    mid();
    check("arst.arb", ready_o[0], 3'b010);
    step();
    valid = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x16 programmable register file between three writeback requesters: 0 = program/debug loader, 1 = ALU writeback, 2 = memory-load writeback.
- Round-robin arbitration with a valid/ready handshake, at most one write per cycle.
- Registered drive of the register-file write signals.
- Exclusive lock mode lets the loader write a burst without interleaving; a watchdog timeout bounds the lock.

Parameters:
- NUM_REQ, 3, number of requesters; fixed at 3 for this revision.
- LOCK_TIMEOUT, 64, maximum consecutive cycles in LOCK before forced release; 1..65535.
- ZERO_REG_PROTECT, 0, when 1, accepted writes to address 0 are acknowledged but not forwarded.

Ports:
- CLK  input  1  single system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- req_valid  input  3  per-requester write request, bit i = requester i.
- req_address  input  9  3-bit destination address per requester, bits [3i+2:3i].
- req_value  input  48  16-bit write data per requester, bits [16i+15:16i].
- req_ready  output  3  combinational one-hot grant, bit i = requester i accepted this cycle.
- lock_req  input  1  loader requests exclusive access.
- lock_ack  output  1  registered, high while in LOCK.
- lock_timeout  output  1  sticky flag: a lock was force-released.
- rf_write  output  1  registered write enable to the register file.
- rf_write_address  output  3  registered write address.
- rf_write_value  output  16  registered write data.
- write_count  output  16  saturating count of writes forwarded to the register file.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = ARB, rr pointer = 0, lock counter = 0.
  - rf_write = 0, rf_write_address = 0, rf_write_value = 0.
  - lock_ack = 0, lock_timeout = 0, write_count = 0.
  - req_ready is forced to 0 while RST_N is low.
  - Reset mid-lock or with a write pending drops that write; no partial write reaches the register file.
- Handshake:
  - A requester holds valid, address and value stable until it sees req_ready high. Transfer occurs on the rising edge with valid & ready.
  - req_ready is never high without the matching req_valid.
  - Dropping valid before ready is allowed: the request is withdrawn and no write occurs.
- ARB state:
  - Priority is searched starting at ptr: ptr, ptr+1, ptr+2 (mod 3). The first valid requester is granted.
  - On a grant to i, ptr <= (i+1) mod 3. With no grant, ptr is unchanged.
  - With all three requesters continuously valid, the grant order is 0, 1, 2, 0, ...; worst-case wait is 2 grants.
- Entering LOCK:
  - If lock_req = 1 in ARB, only requester 0 is eligible that same cycle.
  - state <= LOCK, and lock_ack rises the following cycle.
- LOCK state:
  - Only requester 0 is granted; requesters 1 and 2 see ready = 0.
  - The lock counter increments every cycle.
- Leaving LOCK:
  - On lock_req = 0: state <= ARB, ptr <= 1, counter cleared.
  - If the counter reaches LOCK_TIMEOUT while lock_req is still high: state <= ARB, ptr <= 1, lock_timeout <= 1 (sticky until reset).
  - After a timeout, lock_req must be low for at least 1 cycle before LOCK can be re-entered.
  - When timeout and deassertion happen in the same cycle, the timeout wins and the flag is set.
- Write path (latency 1):
  - The cycle after an accepted transfer: rf_write = 1, with rf_write_address and rf_write_value set to the granted requester's address and value.
  - Otherwise rf_write = 0; address and value hold their last values.
  - Back-to-back grants give back-to-back rf_write pulses, i.e. full throughput.
- ZERO_REG_PROTECT:
  - When 1, a granted write to address 0 still asserts req_ready but produces rf_write = 0 and does not count.
- write_count:
  - Increments on each rf_write pulse and saturates at 0xFFFF; no wrap.
- Reads are not arbitrated. Because register-file reads are clocked, a read issued in the same cycle as an rf_write to the same address returns the old value. Hazard avoidance belongs to the control FSM, not to this block.

Test Plan:
- Reset with all req_valid = 1: ready = 000 while RST_N low. After release, the grant sequence is 001, 010, 100, 001. rf_write follows one cycle later with the matching address/value, e.g. req1 addr 3 value 0xBEEF gives rf_write_address = 3, rf_write_value = 0xBEEF.
- Lock burst: lock_req = 1 while requesters 1 and 2 are valid, requester 0 writing addresses 0..7 with values 0x1000+i. Required: 8 consecutive grants to requester 0, lock_ack high, ready[2:1] = 00. After lock_req drops, requester 1 is granted first.
- Timeout with LOCK_TIMEOUT = 4 and lock_req held: forced release after 4 cycles in LOCK, lock_timeout = 1 and stays 1. LOCK is not re-entered until lock_req is low for 1 cycle.
- ZERO_REG_PROTECT = 1, requester 2 writes addr 0 value 0xFFFF: req_ready[2] = 1, rf_write stays 0, write_count is unchanged. A following write to addr 5 increments write_count by 1.
- Withdrawal and saturation: requester 1 drops valid before its grant, so no write occurs and ptr is unchanged. With write_count preloaded via 65535 writes, the next write leaves it at 0xFFFF.
- Asynchronous reset asserted mid-LOCK with a grant in the same cycle: all outputs return to reset values immediately, no rf_write pulse follows, and state is ARB after release.
